// File: rtl/stage_if_prefetch.sv
// stage_if_prefetch -- instruction-fetch stage with a prefetch queue.
//
// Owns the PC and fetches ahead of decode into a QDEPTH-entry queue. At most
// one ram request is outstanding. Each queue entry is {inst, pc, next_pc} and
// is handed to decode over a valid/ready pair.
//
// Handshakes:
//   ram side    : ram_req_o/ram_addr_o are held stable until the one-cycle
//                 ram_done_i pulse. ram_inst_i is sampled on that cycle.
//   decode side : the head moves on the rising edge where inst_valid_o and
//                 inst_ready_i are both high. A redirect on the same edge
//                 flushes the queue, so that acceptance is void.
//
// Optional feature (macro IF_JAL_PREDICT_EN): a fetched JAL word predicts
// pc + J-immediate as its next PC instead of pc + 4.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   redirect_i, redirect_pc_i     branch/jump redirect strobe and target
//   ram_req_o, ram_addr_o         fetch request and address
//   ram_done_i, ram_inst_i        fetch completion pulse and fetched word
//   inst_valid_o, inst_ready_i    queue head valid / decode accept
//   inst_o, pc_o, next_pc_o       head entry (all zero while the queue is empty)
//   stall_o                       inverse of inst_valid_o
//
// The FSM state is held in state_q (type state_t) for checkers to bind to.
module stage_if_prefetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    QDEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  ram_req_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic                  ram_done_i,
  input  logic [INST_WIDTH-1:0] ram_inst_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic                  stall_o
);

  localparam int             PW       = $clog2(QDEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(QDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                state_q, state_d;

  // fetch_pc_q is always the next address the stage intends to fetch. While
  // discarding, it already holds the redirect target, and the address of the
  // abandoned request is kept in discard_addr_q so ram_addr_o stays stable.
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] discard_addr_q;
  logic [ADDR_WIDTH-1:0] npc;

  logic [CW-1:0]         count_q, count_after;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [INST_WIDTH-1:0] inst_mem [QDEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [QDEPTH];
  logic [ADDR_WIDTH-1:0] npc_mem  [QDEPTH];

  logic                  valid;
  logic                  push;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Next-PC prediction for the word being returned this cycle
  // ---------------------------------------------------------------------------
`ifdef IF_JAL_PREDICT_EN
  logic [20:0] jal_imm;
  assign jal_imm = {ram_inst_i[31], ram_inst_i[19:12], ram_inst_i[20],
                    ram_inst_i[30:21], 1'b0};
  assign npc = (ram_inst_i[6:0] == 7'b1101111)
             ? fetch_pc_q + {{(ADDR_WIDTH-21){jal_imm[20]}}, jal_imm}
             : fetch_pc_q + ADDR_WIDTH'(4);
`else
  assign npc = fetch_pc_q + ADDR_WIDTH'(4);
`endif

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  assign valid = (count_q != '0);
  assign pop   = valid & inst_ready_i;
  // A word returned on a redirect cycle is stale, so it is never pushed. Done
  // pulses outside REQ (idle or discarding) never reach the queue either.
  assign push  = (state_q == ST_REQ) & ram_done_i & ~redirect_i;

  assign count_after = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  assign inst_valid_o = valid;
  assign stall_o      = ~valid;
  assign inst_o       = valid ? inst_mem[rd_ptr_q] : '0;
  assign pc_o         = valid ? pc_mem[rd_ptr_q]   : '0;
  assign next_pc_o    = valid ? npc_mem[rd_ptr_q]  : '0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and ram-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ram_req_o  = 1'b0;
    ram_addr_o = '0;
    case (state_q)
      ST_IDLE: begin
        // A redirect empties the queue, so it always leaves room to fetch.
        if (redirect_i || (count_q < FULL_CNT)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        ram_req_o  = 1'b1;
        ram_addr_o = fetch_pc_q;
        if (redirect_i) begin
          state_d = ram_done_i ? ST_REQ : ST_DISCARD;
        end else if (ram_done_i) begin
          state_d = (count_after < FULL_CNT) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        ram_req_o  = 1'b1;
        ram_addr_o = discard_addr_q;
        if (ram_done_i) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC, pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= '0;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_pc_i;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      // Only the first redirect of an abandoned request captures its address;
      // a later redirect while discarding just retargets fetch_pc_q.
      if ((state_q == ST_REQ) && !ram_done_i) begin
        discard_addr_q <= fetch_pc_q;
      end
    end else begin
      if (push) begin
        fetch_pc_q <= npc;
        wr_ptr_q   <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_after;
    end
  end

  // Queue storage needs no reset: the outputs are masked while it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= ram_inst_i;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      npc_mem[wr_ptr_q]  <= npc;
    end
  end

endmodule

// File: tb/tb_stage_if_prefetch.sv
module tb_stage_if_prefetch;

  localparam int             AW     = 32;
  localparam int             IW     = 32;
  localparam int             QD     = 4;
  localparam int             EW     = IW + 2 * AW;
  localparam logic [AW-1:0]  RST_PC = '0;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          ram_req_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_done_i = 1'b0;
  logic [IW-1:0] ram_inst_i = '0;
  logic          inst_valid_o;
  logic          inst_ready_i = 1'b0;
  logic [IW-1:0] inst_o;
  logic [AW-1:0] pc_o;
  logic [AW-1:0] next_pc_o;
  logic          stall_o;

  always #5 clk = ~clk;

  stage_if_prefetch #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .QDEPTH     (QD),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ram_req_o     (ram_req_o),
    .ram_addr_o    (ram_addr_o),
    .ram_done_i    (ram_done_i),
    .ram_inst_i    (ram_inst_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .next_pc_o     (next_pc_o),
    .stall_o       (stall_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and result counters
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];   // {inst, pc, next_pc} in delivery order
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference next-PC: fall-through is pc+4; a JAL (when predicted) adds the
  // signed J-immediate. Arithmetic is done wide and truncated to AW bits.
  function automatic logic [AW-1:0] model_npc(input logic [IW-1:0] w, input logic [AW-1:0] pc);
`ifdef IF_JAL_PREDICT_EN
    logic signed [20:0] joff;
    if (w[6:0] == 7'b1101111) begin
      joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      return AW'(longint'(pc) + longint'(joff));
    end
`endif
    return AW'(longint'(pc) + 64'd4);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus knobs (written by the sequencer)
  // ---------------------------------------------------------------------------
  int            ready_pct = 100;
  int            lat_min   = 0;
  int            lat_max   = 0;
  int            redir_pct = 0;
  bit            force_redir = 1'b0;
  logic [AW-1:0] force_pc = '0;
  bit            force_jal = 1'b0;

  // Architectural model: the address the stage should fetch next, and whether
  // the request currently on the bus was orphaned by a redirect.
  logic [AW-1:0] exp_pc = RST_PC;
  bit            stale = 1'b0;
  logic [AW-1:0] stale_addr = '0;

  // Ram responder and values driven for the coming edge.
  bit            busy = 1'b0;
  int            lat_cnt = 0;
  int            idle_cnt = 0;
  bit            cur_req = 1'b0;
  bit            cur_done = 1'b0;
  bit            cur_redir = 1'b0;
  logic [AW-1:0] cur_rpc = '0;
  logic [IW-1:0] cur_word = '0;

  // ---------------------------------------------------------------------------
  // Driver: applies the model effect of the edge just taken, checks the ram
  // side, then drives inputs for the next edge.
  // ---------------------------------------------------------------------------
  initial begin : driver
    logic [24:0] hi;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_pc   = RST_PC;
        stale    = 1'b0;
        busy     = 1'b0;
        idle_cnt = 0;
        cur_req  = 1'b0;
        cur_done = 1'b0;
        cur_redir = 1'b0;
        #1;
        // Done pulses during reset must be ignored by the stage.
        ram_done_i    = 1'($urandom_range(0, 1));
        ram_inst_i    = $urandom;
        redirect_i    = 1'b0;
        redirect_pc_i = $urandom;
        inst_ready_i  = 1'($urandom_range(0, 1));
        continue;
      end

      if (cur_redir) begin
        exp_q.delete();
        if (cur_req && !cur_done) begin
          if (!stale) begin
            stale      = 1'b1;
            stale_addr = exp_pc;
          end
        end else begin
          stale = 1'b0;
        end
        exp_pc = cur_rpc;
      end else if (cur_req && cur_done) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          exp_q.push_back({cur_word, exp_pc, model_npc(cur_word, exp_pc)});
          exp_pc = model_npc(cur_word, exp_pc);
        end
      end
      if (cur_done) busy = 1'b0;

      #1;
      cur_req = ram_req_o;
      if (stale) check("req_during_discard", ram_req_o, 1'b1);
      if (!stale && exp_q.size() == QD) check("req_when_full", ram_req_o, 1'b0);
      if (ram_req_o) begin
        check("ram_addr", ram_addr_o, stale ? stale_addr : exp_pc);
        idle_cnt = 0;
      end else if (exp_q.size() < QD) begin
        idle_cnt++;
        if (idle_cnt > 1) begin
          check("req_restart", ram_req_o, 1'b1);
          idle_cnt = 0;
        end
      end

      cur_done = 1'b0;
      if (ram_req_o) begin
        if (!busy) begin
          busy    = 1'b1;
          lat_cnt = $urandom_range(lat_min, lat_max);
        end
        if (lat_cnt == 0) cur_done = 1'b1;
        else lat_cnt--;
      end

      if ($urandom_range(0, 3) == 0) begin
        hi = 25'($urandom);
        cur_word = {hi, 7'b1101111};
      end else begin
        cur_word = $urandom;
      end
      if (force_jal && ram_addr_o == 32'h20) cur_word = 32'h0080006F;

      cur_redir = 1'b0;
      cur_rpc   = $urandom & ~32'h3;
      if (force_redir) begin
        if (ram_req_o && !cur_done && !stale) begin
          cur_redir   = 1'b1;
          cur_rpc     = force_pc;
          force_redir = 1'b0;
        end
      end else if ($urandom_range(0, 99) < redir_pct) begin
        cur_redir = 1'b1;
        if ($urandom_range(0, 7) == 0) cur_rpc = 32'hFFFFFFFC;
      end

      ram_done_i    = cur_done;
      ram_inst_i    = cur_word;
      redirect_i    = cur_redir;
      redirect_pc_i = cur_rpc;
      inst_ready_i  = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares the presented head with the scoreboard and retires it
  // on a non-redirected acceptance.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("stall", stall_o, !inst_valid_o);
        check("valid", inst_valid_o, exp_q.size() != 0);
        if (inst_valid_o && exp_q.size() != 0) begin
          e = exp_q[0];
          check("inst",    inst_o,    e[EW-1 -: IW]);
          check("pc",      pc_o,      e[2*AW-1 -: AW]);
          check("next_pc", next_pc_o, e[AW-1:0]);
          if (inst_ready_i && !redirect_i) void'(exp_q.pop_front());
        end else if (!inst_valid_o) begin
          check("empty_inst",    inst_o,    '0);
          check("empty_pc",      pc_o,      '0);
          check("empty_next_pc", next_pc_o, '0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req",     ram_req_o,    1'b0);
    check("rst_addr",    ram_addr_o,   '0);
    check("rst_valid",   inst_valid_o, 1'b0);
    check("rst_inst",    inst_o,       '0);
    check("rst_pc",      pc_o,         '0);
    check("rst_next_pc", next_pc_o,    '0);
    check("rst_stall",   stall_o,      1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [AW-1:0] pc);
    int n = 0;
    force_pc    = pc;
    force_redir = 1'b1;
    while (force_redir && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (force_redir) begin
      force_redir = 1'b0;
      total++;
      bad++;
      $display("FAIL redirect_timeout actual=pending required=issued pc=%0h", pc);
    end
  endtask

  initial begin : sequencer
    // Reset and first fetch: done two cycles after each request.
    lat_min = 2; lat_max = 2; ready_pct = 100; redir_pct = 0;
    do_reset();
    run(14);

    // Fill to full with decode stalled, then a single pop restarts fetch.
    do_reset();
    lat_min = 0; lat_max = 0; ready_pct = 0;
    run(12);
    ready_pct = 100;
    run(1);
    ready_pct = 0;
    run(8);
    ready_pct = 100;
    run(10);

    // Redirect while a request is pending (done three cycles later).
    lat_min = 3; lat_max = 3;
    redirect_to(32'h100);
    run(20);

    // Redirect near the top of the address space: fetch wraps to zero.
    lat_min = 1; lat_max = 1;
    redirect_to(32'hFFFFFFFC);
    run(10);

    // JAL word at 0x20.
    force_jal = 1'b1;
    redirect_to(32'h20);
    run(12);
    force_jal = 1'b0;

    // Randomized phase, with one reset landing in the middle of traffic.
    for (int blk = 0; blk < 20; blk++) begin
      ready_pct = $urandom_range(0, 100);
      lat_min   = 0;
      lat_max   = $urandom_range(0, 4);
      redir_pct = $urandom_range(0, 15);
      run(200);
      if (blk == 10) do_reset();
    end

    ready_pct = 100; redir_pct = 0; lat_min = 0; lat_max = 0;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
